// File: rtl/sa_ws_sequencer.sv
// sa_ws_sequencer: activation feed controller for a weight-stationary array.
// Reads N vectors, skews them diagonally onto the rows, then counts results.
module sa_ws_sequencer #(
    parameter int SA_ROW        = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int MAX_VEC       = 256,
    parameter int DRAIN_TIMEOUT = 32,
    parameter int CNT_W         = $clog2(MAX_VEC + 1)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             num_vec,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [SA_ROW*DATA_WIDTH-1:0] rd_data,
    output logic                         sa_iv,
    output logic [SA_ROW*DATA_WIDTH-1:0] row_A_o,
    input  logic                         sa_ov,
    output logic [CNT_W-1:0]             ov_count
);

    localparam int CYC_W = CNT_W + 1;
    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] MAX_N    = CNT_W'(MAX_VEC);
    localparam logic [CYC_W-1:0] SKEW     = CYC_W'(SA_ROW - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic                    r_rd_en;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic                    r_sa_iv;
    logic [CNT_W-1:0]        r_ov_count;
    logic [CNT_W-1:0]        r_n;
    logic [CYC_W-1:0]        r_cyc;
    logic [TMR_W-1:0]        r_tmr;
    logic                    r_v0;

    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic                    w_err_nxt;
    logic                    w_rd_en_nxt;
    logic [ADDR_WIDTH-1:0]   w_rd_addr_nxt;
    logic                    w_sa_iv_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        w_n_nxt;
    logic [CYC_W-1:0]        w_cyc_nxt;
    logic [TMR_W-1:0]        w_tmr_nxt;

    logic [CNT_W-1:0]        w_n_sat;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [CYC_W-1:0]        w_last;
    logic [CYC_W-1:0]        w_cyc_inc;
    logic                    w_feed_more;

    logic [DATA_WIDTH-1:0]   w_lane_in [SA_ROW];

    // Job length clamp, result counter step and feed-phase bookkeeping
    always_comb begin
        w_n_sat     = (num_vec > MAX_N) ? MAX_N : num_vec;
        w_cnt_inc   = r_ov_count;
        if (sa_ov && (r_ov_count != r_n)) begin
            w_cnt_inc = r_ov_count + 1'b1;
        end
        w_last      = {1'b0, r_n} + SKEW;
        w_cyc_inc   = r_cyc + 1'b1;
        w_feed_more = (w_cyc_inc < {1'b0, r_n});
    end

    // Sequencer next-state and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_sa_iv_nxt   = 1'b0;
        w_cnt_nxt     = r_ov_count;
        w_n_nxt       = r_n;
        w_cyc_nxt     = r_cyc;
        w_tmr_nxt     = r_tmr;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_vec == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = S_FEED;
                        w_busy_nxt    = 1'b1;
                        w_err_nxt     = 1'b0;
                        w_cnt_nxt     = '0;
                        w_n_nxt       = w_n_sat;
                        w_cyc_nxt     = '0;
                        w_rd_en_nxt   = 1'b1;
                        w_rd_addr_nxt = base_addr;
                    end
                end
            end
            S_FEED: begin
                w_cnt_nxt = w_cnt_inc;
                w_cyc_nxt = w_cyc_inc;
                if (r_cyc == w_last) begin
                    w_state_nxt = S_DRAIN;
                    w_tmr_nxt   = '0;
                end else begin
                    // r_cyc < last, so the next cycle is still a valid beat
                    w_sa_iv_nxt = 1'b1;
                    w_rd_en_nxt = w_feed_more;
                    if (w_feed_more) begin
                        w_rd_addr_nxt = r_rd_addr + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                w_cnt_nxt = w_cnt_inc;
                // A completing beat beats a simultaneous timeout
                if (w_cnt_inc == r_n) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else if (r_tmr == TMR_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_sa_iv    <= 1'b0;
            r_ov_count <= '0;
            r_n        <= '0;
            r_cyc      <= '0;
            r_tmr      <= '0;
            r_v0       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_sa_iv    <= w_sa_iv_nxt;
            r_ov_count <= w_cnt_nxt;
            r_n        <= w_n_nxt;
            r_cyc      <= w_cyc_nxt;
            r_tmr      <= w_tmr_nxt;
            r_v0       <= r_rd_en;
        end
    end

    // Buffer data is only meaningful the cycle after a read; zero otherwise
    always_comb begin
        for (int k = 0; k < SA_ROW; k++) begin
            w_lane_in[k] = '0;
            if (r_v0) begin
                w_lane_in[k] = rd_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Row 0 needs no skew: it follows the buffer output directly
    assign row_A_o[0 +: DATA_WIDTH] = w_lane_in[0];

    for (genvar k = 1; k < SA_ROW; k++) begin : g_skew
        logic [DATA_WIDTH-1:0] r_dly [k];

        // k-stage delay line producing the diagonal skew for row k
        always_ff @(posedge clk or posedge nrst) begin
            if (nrst) begin
                for (int i = 0; i < k; i++) begin
                    r_dly[i] <= '0;
                end
            end else begin
                r_dly[0] <= w_lane_in[k];
                for (int i = 1; i < k; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end
        end

        assign row_A_o[k*DATA_WIDTH +: DATA_WIDTH] = r_dly[k-1];
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign rd_en    = r_rd_en;
    assign rd_addr  = r_rd_addr;
    assign sa_iv    = r_sa_iv;
    assign ov_count = r_ov_count;

endmodule

// File: tb/tb_sa_ws_sequencer.sv
// tb_sa_ws_sequencer: randomized jobs against a cycle-indexed reference model.
// Buffer, array results and expected waveforms are all produced here.
module tb_sa_ws_sequencer;

    localparam int SA_ROW = 3;
    localparam int DW     = 8;
    localparam int AW     = 10;
    localparam int MAXV   = 256;
    localparam int TMO    = 32;
    localparam int CNT_W  = $clog2(MAXV + 1);
    localparam int VW     = SA_ROW * DW;
    localparam int DEPTH  = 1 << AW;

    logic             clk = 1'b0;
    logic             nrst;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic [AW-1:0]    base_addr;
    logic             busy;
    logic             done;
    logic             err;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [VW-1:0]    rd_data;
    logic             sa_iv;
    logic [VW-1:0]    row_A_o;
    logic             sa_ov;
    logic [CNT_W-1:0] ov_count;

    int n_tot = 0;
    int n_bad = 0;

    logic [VW-1:0] mem [DEPTH];
    logic          smp_en;
    logic [AW-1:0] smp_addr;

    always #5 clk = ~clk;

    sa_ws_sequencer #(
        .SA_ROW(SA_ROW),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_VEC(MAXV),
        .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .start(start),
        .num_vec(num_vec),
        .base_addr(base_addr),
        .busy(busy),
        .done(done),
        .err(err),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .sa_iv(sa_iv),
        .row_A_o(row_A_o),
        .sa_ov(sa_ov),
        .ov_count(ov_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Synchronous-read buffer: data appears the cycle after rd_en, junk otherwise
    initial begin
        rd_data = '0;
        forever begin
            @(negedge clk);
            smp_en   = rd_en;
            smp_addr = rd_addr;
            @(posedge clk);
            #1;
            rd_data = smp_en ? mem[smp_addr] : VW'($urandom);
        end
    end

    // Row k shows vector (t-2-k) of the job in cycle t after start, else 0
    function automatic logic [VW-1:0] exp_row(int base, int n, int t);
        logic [VW-1:0] v;
        logic [VW-1:0] w;
        int j;
        v = '0;
        for (int k = 0; k < SA_ROW; k++) begin
            j = t - 2 - k;
            if (j >= 0 && j < n) begin
                w = mem[(base + j) % DEPTH];
                v[k*DW +: DW] = w[k*DW +: DW];
            end
        end
        return v;
    endfunction

    task automatic chk_idle_zero(input string nm);
        chk({nm, ".busy"},  busy,     0);
        chk({nm, ".done"},  done,     0);
        chk({nm, ".err"},   err,      0);
        chk({nm, ".rden"},  rd_en,    0);
        chk({nm, ".raddr"}, rd_addr,  0);
        chk({nm, ".iv"},    sa_iv,    0);
        chk({nm, ".row"},   row_A_o,  0);
        chk({nm, ".cnt"},   ov_count, 0);
    endtask

    // Entered and left just after a falling edge; start is sampled next edge.
    // Beats: nb beats at cycles b0, b0+gap, ... relative to the start edge.
    task automatic run_job(input string nm, input int nv, input int base,
                           input int nb, input int b0, input int gap,
                           input bit glitch);
        int n;
        int last;
        int td;
        int cnt;
        int ecnt;
        bit tmo;
        bit bt [0:1023];
        n    = (nv > MAXV) ? MAXV : nv;
        last = n + SA_ROW;
        for (int i = 0; i < 1024; i++) bt[i] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (b0 + i * gap < 1024) bt[b0 + i * gap] = 1'b1;
        end
        tmo = 1'b1;
        td  = last + TMO + 1;
        cnt = 0;
        for (int t = 1; t <= last + TMO; t++) begin
            if (bt[t]) cnt++;
            if (t > last && cnt >= n) begin
                td  = t + 1;
                tmo = 1'b0;
                break;
            end
        end

        start     = 1'b1;
        num_vec   = CNT_W'(nv);
        base_addr = AW'(base);
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_vec   = CNT_W'($urandom);
        base_addr = AW'($urandom);
        sa_ov     = bt[1];
        ecnt      = 0;
        for (int t = 1; t <= td + 1; t++) begin
            @(negedge clk);
            chk({nm, ".rden"}, rd_en, (t <= n));
            if (t <= n) chk({nm, ".raddr"}, rd_addr, (base + t - 1) % DEPTH);
            chk({nm, ".iv"},   sa_iv, (t >= 2 && t <= last));
            chk({nm, ".row"},  row_A_o, exp_row(base, n, t));
            chk({nm, ".busy"}, busy, (t < td));
            chk({nm, ".done"}, done, (t == td));
            chk({nm, ".err"},  err, (t >= td) ? tmo : 1'b0);
            chk({nm, ".cnt"},  ov_count, ecnt);
            if (t < td && bt[t] && ecnt < n) ecnt++;
            if (t <= td) begin
                @(posedge clk);
                #1;
                sa_ov = bt[t + 1];
                start = glitch && (t == 2);
            end
        end
        sa_ov = 1'b0;
        start = 1'b0;
    endtask

    task automatic zero_job();
        start     = 1'b1;
        num_vec   = '0;
        base_addr = AW'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero.done1", done,  1);
        chk("zero.busy",  busy,  0);
        chk("zero.rden",  rd_en, 0);
        chk("zero.iv",    sa_iv, 0);
        @(negedge clk);
        chk("zero.done2", done,  0);
        chk("zero.rden2", rd_en, 0);
        chk("zero.iv2",   sa_iv, 0);
    endtask

    task automatic reset_mid_feed();
        start     = 1'b1;
        num_vec   = CNT_W'(6);
        base_addr = AW'(100);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rstm.pre_iv",   sa_iv, 1);
        chk("rstm.pre_rden", rd_en, 1);
        #1;
        nrst = 1'b1;
        #1;
        chk_idle_zero("rstm");
        @(negedge clk);
        chk_idle_zero("rstm.hold");
        @(posedge clk);
        #3;
        nrst = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_beats(input int exp_cnt);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            sa_ov = 1'b1;
        end
        @(negedge clk);
        sa_ov = 1'b0;
        chk("idle.cnt",  ov_count, exp_cnt);
        chk("idle.busy", busy, 0);
        chk("idle.done", done, 0);
    endtask

    initial begin
        int nv;
        int base;
        int mode;
        int nb;
        int b0;
        int gap;
        start     = 1'b0;
        sa_ov     = 1'b0;
        num_vec   = '0;
        base_addr = '0;
        nrst      = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = VW'($urandom);
        #1;
        nrst = 1'b1;
        #1;
        chk_idle_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);

        for (int j = 0; j < 8; j++) mem[200 + j] = {8'd1, 8'd2, 8'd3};
        run_job("plan8", 8, 200, 8, 17, 1, 1'b0);
        idle_beats(8);

        run_job("tmo", 8, 300, 5, 4, 2, 1'b0);
        run_job("wrap", 4, 1022, 4, 10, 1, 1'b1);
        run_job("b2b", 5, 40, 5, 3, 1, 1'b0);

        zero_job();
        reset_mid_feed();
        run_job("post_rst", 6, 100, 6, 12, 1, 1'b0);

        run_job("sat", 300, 700, 0, 1, 1, 1'b0);

        for (int r = 0; r < 14; r++) begin
            nv   = $urandom_range(1, 12);
            base = $urandom_range(0, DEPTH - 1);
            mode = $urandom_range(0, 2);
            gap  = $urandom_range(1, 2);
            b0   = $urandom_range(1, nv + SA_ROW + 12);
            nb   = (mode == 0) ? nv :
                   (mode == 1) ? $urandom_range(0, nv - 1) : nv + 3;
            run_job("rnd", nv, base, nb, b0, gap, 1'($urandom_range(0, 1)));
            if (r == 6) zero_job();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/sa_ws_sequencer.md
Name: sa_ws_sequencer

Overview:
Feed controller for SA_WS_conv. On a start command it reads N unskewed activation vectors (one element per SA row) from an activation buffer. It applies the diagonal input skew the weight-stationary array requires and drives sa_iv/row_A_o. It then counts the returning sa_ov beats and signals done, or err on timeout. Its outputs connect directly to SA_WS_conv sa_iv/row_A_i; sa_ov is tapped from the array output, and the bias_adder/reLU chain is unaffected.

Parameters:
SA_ROW, 3, array rows = elements per activation vector
DATA_WIDTH, 8, activation element width
ADDR_WIDTH, 10, activation buffer address width
MAX_VEC, 256, largest legal num_vec; CNT_W = $clog2(MAX_VEC+1)
DRAIN_TIMEOUT, 32, cycles allowed after last sa_iv beat for outstanding sa_ov beats

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  reset, asynchronous, active-high (1 = reset), despite the name
start  in  1  one-cycle job request; honoured only when busy=0
num_vec  in  CNT_W  vectors in job, sampled with start
base_addr  in  ADDR_WIDTH  buffer address of vector 0, sampled with start
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
err  out  1  sticky timeout flag, cleared by next accepted start
rd_en  out  1  buffer read strobe
rd_addr  out  ADDR_WIDTH  buffer read address
rd_data  in  SA_ROW*DATA_WIDTH  vector, element k at [k*DATA_WIDTH +: DATA_WIDTH], valid 1 cycle after rd_en
sa_iv  out  1  array input valid
row_A_o  out  SA_ROW*DATA_WIDTH  skewed row inputs to the array
sa_ov  in  1  array output valid, one beat per result vector
ov_count  out  CNT_W  sa_ov beats counted in current job

Behaviour:
- Reset (async, while nrst=1): state IDLE; busy, done, err, rd_en, sa_iv = 0; rd_addr, row_A_o, ov_count, all skew registers = 0. Outputs take these values immediately, mid-job included. The job is abandoned; no done pulse is issued.
- States: IDLE -> FEED -> DRAIN -> IDLE. All outputs are registered.
- IDLE: start=1 and num_vec>0 at edge S: latch N and base, clear err and ov_count, busy=1, enter FEED. start=1 with num_vec=0: done pulses at S+1 and busy stays 0. num_vec>MAX_VEC is saturated to MAX_VEC.
- FEED: rd_en=1 during cycles S+1..S+N with rd_addr = base+j for j=0..N-1; address wraps modulo 2^ADDR_WIDTH. Vector j element k appears on row_A_o[k] in cycle T0+j+k, where T0 = S+2. Skew uses a k-stage delay line per row k. Lanes with no valid element drive 0.
- sa_iv=1 for exactly N+SA_ROW-1 consecutive cycles, T0..T0+N+SA_ROW-2. At the last sa_iv cycle, enter DRAIN; row_A_o = 0 afterwards.
- sa_ov: counted in any busy state, including FEED. Beats outside busy are ignored.
- DRAIN: if ov_count reaches N, done=1 next cycle, busy=0, return to IDLE. If DRAIN_TIMEOUT cycles pass without reaching N: err=1, done=1, return to IDLE.
- Extra sa_ov beats beyond N within a job: ov_count saturates at N.
- start while busy: ignored, no side effects.
- Simultaneous final sa_ov and timeout expiry in the same cycle: the count wins and err stays 0.
- Next job may start in the cycle after done.

Test Plan:
- Reset mid-FEED (nrst=1 at T0+3) -> sa_iv, rd_en, busy, row_A_o = 0 immediately. After release, a fresh start works normally.
- N=8, SA_ROW=3, every rd_data={1,2,3} (elements 2,1,0) -> row_A_o {0,0,3},{0,2,3},{1,2,3}x6,{1,2,0},{1,0,0}. sa_iv high exactly 10 cycles starting S+2. rd_addr base..base+7.
- Drive 8 sa_ov beats 6 cycles after last sa_iv -> done single pulse, err=0, ov_count=8, busy low.
- Drive only 5 sa_ov beats -> err=1 and done exactly DRAIN_TIMEOUT=32 cycles after DRAIN entry; err cleared by next start.
- start with num_vec=0 -> done at S+1, no rd_en, no sa_iv. start pulse during FEED -> ignored, sequence unchanged.
- base_addr=1022, N=4, ADDR_WIDTH=10 -> rd_addr 1022,1023,0,1. Back-to-back jobs with start in the cycle after done -> second job's sa_iv begins 2 cycles after its start.
